// File: rtl/alu_core_if.sv
// rtl/alu_core_if.sv - operand/opcode/result bundle between the register file side and the ALU
// Purpose: groups the ALU operands, opcode, flag-write strobe and all results into one bundle.
// Ports (as interface signals):
//   InputA, InputB [7:0], SC_in, OP [2:0], FlagWe    driven by the master (register file side)
//   Out [7:0], Zero, Equal, Even, SC_out, FlagC, FlagZ driven by the slave (alu_core)
interface alu_core_if;
   logic [7:0] InputA;
   logic [7:0] InputB;
   logic       SC_in;
   logic [2:0] OP;
   logic       FlagWe;
   logic [7:0] Out;
   logic       Zero;
   logic       Equal;
   logic       Even;
   logic       SC_out;
   logic       FlagC;
   logic       FlagZ;

   modport master (
      output InputA, InputB, SC_in, OP, FlagWe,
      input  Out, Zero, Equal, Even, SC_out, FlagC, FlagZ
   );

   modport slave (
      input  InputA, InputB, SC_in, OP, FlagWe,
      output Out, Zero, Equal, Even, SC_out, FlagC, FlagZ
   );
endinterface

// File: rtl/alu_core.sv
// rtl/alu_core.sv - 8-bit combinational ALU with a registered carry/zero flag pair
// Purpose: same-cycle result, zero, equal, even and shift/carry-out from the operands and opcode;
//          carry and zero are captured into flag registers when FlagWe is high.
// Ports:
//   Clk    rising-edge clock, used only by the flag registers
//   Reset  synchronous active-high, clears the flag registers only
//   bus    alu_core_if slave modport carrying operands, opcode, FlagWe and all results
module alu_core #(
   parameter int W = 8
) (
   input  logic        Clk,
   input  logic        Reset,
   alu_core_if.slave   bus
);

   localparam logic [2:0] OP_ADD  = 3'b000;
   localparam logic [2:0] OP_LSL  = 3'b001;
   localparam logic [2:0] OP_LSR  = 3'b010;
   localparam logic [2:0] OP_XOR  = 3'b011;
   localparam logic [2:0] OP_SNE  = 3'b100;
   localparam logic [2:0] OP_SEQ  = 3'b101;
   localparam logic [2:0] OP_MSK  = 3'b110;
   localparam logic [2:0] OP_PASS = 3'b111;

   logic [W:0]   sum;
   logic [W-1:0] result;
   logic         sc_out;
   logic         equal;

   logic         flag_c_d;
   logic         flag_c_q;
   logic         flag_z_d;
   logic         flag_z_q;

   assign equal = (bus.InputA == bus.InputB);

   always_comb begin
      // Ninth bit of the widened sum is the carry out.
      sum    = {1'b0, bus.InputA} + {1'b0, bus.InputB} + {{W{1'b0}}, bus.SC_in};
      result = '0;
      sc_out = 1'b0;
      case (bus.OP)
         OP_ADD: begin
            result = sum[W-1:0];
            sc_out = sum[W];
         end
         OP_LSL: begin
            result = {bus.InputA[W-2:0], bus.SC_in};
            sc_out = bus.InputA[W-1];
         end
         OP_LSR: begin
            result = {1'b0, bus.InputA[W-1:1]};
            sc_out = bus.InputA[0];
         end
         OP_XOR: result = bus.InputA ^ bus.InputB;
         OP_SNE: result = equal ? '0 : W'(1);
         OP_SEQ: result = equal ? W'(1) : '0;
         // Single-bit test: only B[2:0] selects the bit, upper B bits are ignored.
         OP_MSK: result = bus.InputA & (W'(1) << bus.InputB[2:0]);
         OP_PASS: result = bus.InputB;
         default: result = '0;
      endcase
   end

   assign bus.Out    = result;
   assign bus.Zero   = (result == '0);
   assign bus.Equal  = equal;
   assign bus.Even   = ~result[0];
   assign bus.SC_out = sc_out;

   always_comb begin
      flag_c_d = flag_c_q;
      flag_z_d = flag_z_q;
      if (bus.FlagWe) begin
         flag_c_d = sc_out;
         flag_z_d = (result == '0);
      end
   end

   // Reset takes priority over a simultaneous flag write.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         flag_c_q <= 1'b0;
         flag_z_q <= 1'b0;
      end else begin
         flag_c_q <= flag_c_d;
         flag_z_q <= flag_z_d;
      end
   end

   assign bus.FlagC = flag_c_q;
   assign bus.FlagZ = flag_z_q;

endmodule

// File: tb/tb_alu_core.sv
// tb/tb_alu_core.sv - self-checking random and directed bench for alu_core
module tb_alu_core;

   logic Clk = 1'b0;
   logic Reset;
   always #5 Clk = ~Clk;

   alu_core_if bus ();

   alu_core dut (
      .Clk   (Clk),
      .Reset (Reset),
      .bus   (bus)
   );

   int checks = 0;
   int errors = 0;
   int mc = 0;
   int mz = 0;

   task automatic check(input string tag, input logic [31:0] got, input int exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic void ref_alu(input int a, input int b, input int c, input int op,
                                   output int o, output int sc);
      int s;
      sc = 0;
      case (op)
         0: begin s = a + b + c; o = s % 256; sc = (s >= 256) ? 1 : 0; end
         1: begin o = (a * 2 + c) % 256; sc = (a >= 128) ? 1 : 0; end
         2: begin o = a / 2; sc = a % 2; end
         3: o = a ^ b;
         4: o = (a != b) ? 1 : 0;
         5: o = (a == b) ? 1 : 0;
         6: o = a & (1 << (b % 8));
         default: o = b;
      endcase
   endfunction

   task automatic apply(input int a, input int b, input int c, input int op,
                        input int we, input int rst);
      int o;
      int sc;
      @(negedge Clk);
      bus.InputA = a[7:0];
      bus.InputB = b[7:0];
      bus.SC_in  = c[0];
      bus.OP     = op[2:0];
      bus.FlagWe = we[0];
      Reset      = rst[0];
      #1;
      ref_alu(a, b, c, op, o, sc);
      check("out",    {24'b0, bus.Out},    o);
      check("zero",   {31'b0, bus.Zero},   (o == 0) ? 1 : 0);
      check("equal",  {31'b0, bus.Equal},  (a == b) ? 1 : 0);
      check("even",   {31'b0, bus.Even},   (o % 2 == 0) ? 1 : 0);
      check("sc_out", {31'b0, bus.SC_out}, sc);
      check("flag_c", {31'b0, bus.FlagC},  mc);
      check("flag_z", {31'b0, bus.FlagZ},  mz);
      if (rst != 0) begin
         mc = 0;
         mz = 0;
      end else if (we != 0) begin
         mc = sc;
         mz = (o == 0) ? 1 : 0;
      end
   endtask

   initial begin
      Reset      = 1'b1;
      bus.InputA = 8'h00;
      bus.InputB = 8'h00;
      bus.SC_in  = 1'b0;
      bus.OP     = 3'b000;
      bus.FlagWe = 1'b1;
      @(posedge Clk);
      @(posedge Clk);
      mc = 0;
      mz = 0;

      // Directed vectors: a, b, sc_in, op, flag_we, reset
      apply(8'h01, 8'h01, 0, 0, 0, 0);
      apply(8'hFF, 8'h01, 0, 0, 1, 0);
      apply(8'h04, 8'h00, 0, 1, 0, 0);
      apply(8'h04, 8'h00, 0, 2, 0, 0);
      apply(8'h81, 8'h00, 1, 2, 0, 0);
      apply(8'h02, 8'h06, 0, 3, 0, 0);
      apply(8'h00, 8'h01, 0, 4, 0, 0);
      apply(8'h00, 8'h00, 0, 4, 0, 0);
      apply(8'h00, 8'h00, 0, 5, 0, 0);
      apply(8'h05, 8'h05, 0, 5, 0, 0);
      apply(8'h07, 8'h02, 0, 6, 0, 0);
      apply(8'h07, 8'h0B, 0, 6, 0, 0);
      apply(8'h0F, 8'h0B, 0, 6, 0, 0);
      apply(8'h3C, 8'hA5, 1, 7, 0, 0);
      apply(8'hFF, 8'h01, 0, 0, 1, 0);
      apply(8'hFF, 8'h01, 0, 0, 1, 1);
      apply(8'h80, 8'h80, 1, 0, 1, 0);
      apply(8'h80, 8'h00, 1, 1, 0, 0);
      apply(8'h00, 8'h00, 0, 3, 0, 0);

      for (int i = 0; i < 400; i++) begin
         apply(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
               int'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
               int'($urandom_range(0, 1)), ($urandom_range(0, 15) == 0) ? 1 : 0);
      end
      apply(0, 0, 0, 0, 0, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
